// File: rtl/orderbook_pkg.sv
// orderbook_pkg: command layout, type codes and frame length table shared by the orderbook blocks.
package orderbook_pkg;
    localparam int CMD_W      = 312;
    localparam int OFF_TYPE   = 296;
    localparam int OFF_SIDE   = 288;
    localparam int OFF_OID    = 224;
    localparam int OFF_QTY    = 192;
    localparam int OFF_SYM    = 128;
    localparam int OFF_PRICE  = 64;
    localparam int OFF_EXEC   = 32;
    localparam int OFF_CANCEL = 0;
    // Only the low type byte is kept after acceptance; the high byte just gates validity.
    localparam int REG_W      = OFF_TYPE + 8;
    localparam int BODY_W     = 232;
    localparam logic [4:0] MAX_BODY = 5'd29;

    typedef enum logic [7:0] {
        CMD_ADD     = 8'h01,
        CMD_EXEC    = 8'h02,
        CMD_REDUCE  = 8'h03,
        CMD_MODIFY  = 8'h04,
        CMD_DELETE  = 8'h05,
        CMD_GET_ALL = 8'h06,
        CMD_GET_TOP = 8'h07
    } cmd_type_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_TYPE, ST_BODY} ser_state_e;

    // Frame length N (bytes after the length byte); 0 marks an unsupported command.
    function automatic logic [4:0] frame_len(input logic [15:0] t);
        case (t)
            {8'h00, CMD_ADD}:                        frame_len = 5'd30;
            {8'h00, CMD_EXEC}, {8'h00, CMD_REDUCE}:  frame_len = 5'd13;
            {8'h00, CMD_MODIFY}:                     frame_len = 5'd21;
            {8'h00, CMD_DELETE}:                     frame_len = 5'd9;
            {8'h00, CMD_GET_ALL}, {8'h00, CMD_GET_TOP}: frame_len = 5'd1;
            default:                                 frame_len = 5'd0;
        endcase
    endfunction
endpackage

// File: rtl/orderbook_field_mux.sv
// orderbook_field_mux: picks body byte i_idx of a registered command, fields MSB first.
module orderbook_field_mux
    import orderbook_pkg::*;
(
    input  logic [REG_W-1:0] i_cmd,
    input  logic [4:0]       i_idx,
    output logic [7:0]       o_byte
);
    logic [7:0]        w_type;
    logic [63:0]       w_oid, w_sym, w_price;
    logic [31:0]       w_qty, w_exec, w_cancel;
    logic [BODY_W-1:0] w_body;

    assign w_type   = i_cmd[OFF_TYPE +: 8];
    assign w_oid    = i_cmd[OFF_OID +: 64];
    assign w_sym    = i_cmd[OFF_SYM +: 64];
    assign w_price  = i_cmd[OFF_PRICE +: 64];
    assign w_qty    = i_cmd[OFF_QTY +: 32];
    assign w_exec   = i_cmd[OFF_EXEC +: 32];
    assign w_cancel = i_cmd[OFF_CANCEL +: 32];

    // Each type's body is packed left-aligned so byte i sits at a fixed offset from the top.
    assign w_body = (w_type == CMD_ADD)    ? {i_cmd[OFF_SIDE +: 8], w_oid, w_qty, w_sym, w_price} :
                    (w_type == CMD_EXEC)   ? {w_oid, w_exec, 136'd0} :
                    (w_type == CMD_REDUCE) ? {w_oid, w_cancel, 136'd0} :
                    (w_type == CMD_MODIFY) ? {w_oid, w_qty, w_price, 72'd0} :
                    (w_type == CMD_DELETE) ? {w_oid, 168'd0} : '0;

    assign o_byte = (i_idx < MAX_BODY) ? w_body[{5'd28 - i_idx, 3'b000} +: 8] : 8'h00;
endmodule

// File: rtl/orderbook_cmd_serializer.sv
// orderbook_cmd_serializer: turns accepted OrderBook commands into length-prefixed byte frames.
module orderbook_cmd_serializer
    import orderbook_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CMD_W-1:0]       cmd_in,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    output logic                   byte_last,
    input  logic                   byte_ready,
    output logic                   bad_cmd,
    output logic [COUNT_WIDTH-1:0] frame_count
);
    ser_state_e             r_state;
    logic [REG_W-1:0]       r_cmd;
    logic [4:0]             r_len, r_idx;
    logic [7:0]             r_byte;
    logic                   r_valid, r_last, r_bad;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [4:0]             w_in_len, w_mux_idx;
    logic [7:0]             w_mux_byte;

    assign w_in_len    = frame_len(cmd_in[OFF_TYPE +: 16]);
    // Index of the body byte loaded next: 0 when leaving TYPE, else the following one.
    assign w_mux_idx   = (r_state == ST_BODY) ? r_idx + 5'd1 : 5'd0;
    assign cmd_ready   = (r_state == ST_IDLE) & ~reset;
    assign byte_out    = r_byte;
    assign byte_valid  = r_valid;
    assign byte_last   = r_last;
    assign bad_cmd     = r_bad;
    assign frame_count = r_count;

    orderbook_field_mux u_mux (
        .i_cmd  (r_cmd),
        .i_idx  (w_mux_idx),
        .o_byte (w_mux_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_bad   <= 1'b0;
            r_count <= '0;
        end else begin
            r_bad <= 1'b0;
            case (r_state)
                ST_IDLE: if (cmd_valid) begin
                    if (w_in_len == 5'd0) begin
                        r_bad <= 1'b1;
                    end else begin
                        r_cmd   <= cmd_in[REG_W-1:0];
                        r_len   <= w_in_len;
                        r_byte  <= {3'b000, w_in_len};
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: if (byte_ready) begin
                    r_byte  <= r_cmd[OFF_TYPE +: 8];
                    r_last  <= (r_len == 5'd1);
                    r_state <= ST_TYPE;
                end
                default: if (byte_ready) begin
                    if (r_last) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_byte  <= '0;
                        r_idx   <= '0;
                        r_count <= r_count + 1'b1;
                    end else begin
                        r_idx   <= w_mux_idx;
                        r_byte  <= w_mux_byte;
                        r_last  <= (w_mux_idx == r_len - 5'd2);
                        r_state <= ST_BODY;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/orderbook_cmd_serializer.md
ORDERBOOK_CMD_SERIALIZER -- requirements
Module: orderbook_cmd_serializer

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32, width of frame_count.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port cmd_in, input, 312, OrderBook command: [311:296] command_type, [295:288] side, [287:224] order_id, [223:192] quantity, [191:128] symbol, [127:64] price, [63:32] executed_quantity, [31:0] cancelled_quantity.
REQ-005 SHALL have port cmd_valid, input, 1, cmd_in is valid.
REQ-006 SHALL have port cmd_ready, output, 1, serializer accepts a command.
REQ-007 SHALL have port byte_out, output, 8, frame byte.
REQ-008 SHALL have port byte_valid, output, 1, byte_out is valid.
REQ-009 SHALL have port byte_last, output, 1, final byte of the frame, qualified by byte_valid.
REQ-010 SHALL have port byte_ready, input, 1, downstream consumes the byte.
REQ-011 SHALL have port bad_cmd, output, 1, one-cycle pulse when a command is dropped.
REQ-012 SHALL have port frame_count, output, COUNT_WIDTH, number of frames completed, wraps modulo 2^COUNT_WIDTH.

Function
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high; a byte SHALL be transferred on a rising edge where byte_valid and byte_ready are both high.
REQ-014 Frame format SHALL be: length byte N (count of following bytes), type byte (command_type[7:0]), then type fields, multi-byte fields most-significant byte first.
REQ-015 Type 0x01 AddOrder: side, order_id, quantity, symbol, price; N=30.
REQ-016 Type 0x02 OrderExecuted: order_id, executed_quantity; N=13.
REQ-017 Type 0x03 ReduceSize: order_id, cancelled_quantity; N=13.
REQ-018 Type 0x04 ModifyOrder: order_id, quantity, price; N=21.
REQ-019 Type 0x05 DeleteOrder: order_id; N=9.
REQ-020 Types 0x06 GetAllOrders and 0x07 GetTop: type byte only; N=1.
REQ-021 Any other command_type (including nonzero [15:8]) SHALL be dropped: no bytes emitted, bad_cmd pulsed the cycle after acceptance, cmd_ready high again that same cycle.
REQ-022 FSM states: IDLE, LEN, TYPE, BODY; IDLE->LEN on valid accept, LEN->TYPE and TYPE->BODY on byte transfer, TYPE->IDLE when N=1, BODY->IDLE on transfer of byte_last.
REQ-023 cmd_ready SHALL be high only in IDLE; the accepted command SHALL be registered, so cmd_in may change after acceptance.
REQ-024 byte_valid SHALL assert the cycle after acceptance (latency 1); total frame occupancy N+1 transfer cycles with byte_ready held high.
REQ-025 byte_out, byte_valid, byte_last SHALL be registered and held stable while byte_valid is high and byte_ready low.
REQ-026 byte_valid SHALL never be withdrawn before transfer; no idle bubble between bytes of one frame when byte_ready is high.
REQ-027 A new command SHALL NOT be accepted in the cycle byte_last transfers; earliest next acceptance is the following cycle (one IDLE cycle between frames).
REQ-028 frame_count SHALL increment by one on the byte_last transfer; dropped commands SHALL NOT count.
REQ-029 Body byte index counter SHALL be 5 bits and compare against the per-type length table; no out-of-range field bytes emitted.

Reset
REQ-030 On reset assertion, at any time including mid-frame: state IDLE, cmd_ready 0 while reset high, byte_valid 0, byte_last 0, byte_out 0x00, bad_cmd 0, frame_count 0, index 0.
REQ-031 A partially sent frame SHALL be abandoned without completion; cmd_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-032 Command-type codes, field bit offsets, and the per-type length table SHALL live in shared package orderbook_pkg, reused by the parser and the order book.
REQ-033 Field-to-byte selection SHALL be a combinational sub-module orderbook_field_mux (type, index, registered command -> byte); FSM, counters and handshake stay in the top.

Verification
REQ-034 DeleteOrder, order_id 0x0102030405060708, byte_ready=1 -> bytes 09 05 01 02 03 04 05 06 07 08, byte_last on 08, frame_count 1.
REQ-035 OrderExecuted, order_id 0x11, executed 0x000000C8, byte_ready toggling 1/0 -> 0D 02 00*7 11 00 00 00 C8, each byte held stable during stalls.
REQ-036 AddOrder side 0x42 ('B'), qty 100, symbol "AAPL    ", price 0x1234 -> 31 output bytes, N=0x1E, symbol bytes 41 41 50 4C 20 20 20 20.
REQ-037 command_type 0x0009 then GetTop -> bad_cmd pulse, no bytes for the first; then 01 07 with byte_last on 07; frame_count 1.
REQ-038 Reset asserted at byte 5 of AddOrder -> byte_valid 0 immediately, frame_count 0; next DeleteOrder emits a complete correct frame.
REQ-039 cmd_valid held high with back-to-back DeleteOrders -> exactly one IDLE cycle between frames, no lost or duplicated command.
